sfp_norm: RTL and testbench
===========================

SFP_NORM -- requirements
Module: sfp_norm

Interface
REQ-001 Param COL, 8, number of psum lanes per row.
REQ-002 Param PSUM_BW, 16, signed psum lane width.
REQ-003 Param FRAC, 8, fractional bits of normalized output; quotient 1.0 = 2^FRAC.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 acc  in  1  accumulate command (controller inst[18]); samples sfp_in.
REQ-007 div  in  1  divide command (controller inst[17]); starts normalization of the held row.
REQ-008 sfp_in  in  COL*PSUM_BW  packed signed psum row; lane 0 in LSBs.
REQ-009 sfp_out  out  COL*PSUM_BW  packed signed normalized row.
REQ-010 out_valid  out  1  one-cycle pulse; sfp_out valid.
REQ-011 sfp_ready  out  1  high when a command is accepted (drives controller sfp_ready).
REQ-012 sum_valid  out  1  level; the held row has a computed sum.
REQ-013 sum_local  out  PSUM_BW+4  registered sum of |lane| for the held row.

Function
REQ-014 States: IDLE, ACCUM, DIV, DONE.
REQ-015 sfp_ready SHALL be 1 only in IDLE.
REQ-016 IDLE with acc=1: latch sfp_in into the row register and go to ACCUM; acc wins if acc and div are both high (div dropped).
REQ-017 ACCUM, one cycle: sum_local = sum over lanes of |lane|, unsigned; |-2^(PSUM_BW-1)| = 2^(PSUM_BW-1) exactly; set sum_valid=1; go to IDLE.
REQ-018 IDLE with div=1 and sum_valid=1: latch divisor D (REQ-030), go to DIV, clear iteration counter.
REQ-019 IDLE with div=1 and sum_valid=0: command ignored, no state change, no out_valid.
REQ-020 DIV: restoring division, all lanes in parallel, one quotient bit per cycle, dividend |lane|<<FRAC, exactly FRAC+1 iterations.
REQ-021 Quotient per lane is at most 2^FRAC (|lane| <= D); final lane = quotient with the original lane sign reapplied, sign-extended to PSUM_BW.
REQ-022 D=0: divider runs the same cycle count and the output lanes are all 0.
REQ-023 After the last iteration go to DONE; in DONE, out_valid=1 for exactly one cycle, then go to IDLE and clear sum_valid.
REQ-024 Latency: div accepted at cycle t gives out_valid at cycle t+FRAC+2; fixed and data-independent.
REQ-025 sfp_out SHALL hold its last value until the next DONE.
REQ-026 acc or div outside IDLE is ignored with no side effect.
REQ-027 A new acc in IDLE with sum_valid=1 overwrites the held row and sum.

Reset
REQ-028 Reset SHALL force IDLE and clear these to 0: sfp_out, out_valid, sum_valid, sum_local, divider registers and counter. sfp_ready=1 from the first cycle after reset.
REQ-029 Reset asserted during DIV aborts the operation: no out_valid, held row discarded.

Configuration
REQ-030 Macro SFP_EXT_SUM_EN, when defined:
  - adds port sum_in (in, PSUM_BW+4): partner-core sum.
  - adds port sum_out (out, PSUM_BW+4): equals sum_local.
  - D = sum_local + sum_in, computed at div acceptance, PSUM_BW+5 bits, no overflow.
  Without the macro: neither port exists and D = sum_local.

Verification
REQ-031 Row [100,-100,0,0,0,0,0,0]: acc, then div -> sum_local=200; out_valid at t+10; sfp_out lanes [128,-128,0,...].
REQ-032 Row [1,1,1,1,1,1,1,1]: acc, div -> every lane 32; row [-32768,0,...] -> lane0 = -256, others 0.
REQ-033 All-zero row: acc, div -> sum_local=0; out_valid at t+10; all lanes 0.
REQ-034 div with sum_valid=0 -> ignored; no out_valid. acc and div in the same cycle -> only acc takes effect.
REQ-035 Reset pulse at cycle t+4 of DIV -> no out_valid; sfp_ready=1 and sum_valid=0 on the next cycle.
REQ-036 SFP_EXT_SUM_EN defined: row [100,0,...], sum_in=300 -> lane0 = 64; sum_out=100.

Source files
------------

// File: rtl/sfp_norm.sv
// Psum row normalizer: accumulates sum of |lane| for a held row, then divides every lane by it.
// Optional macro SFP_EXT_SUM_EN adds sum_in/sum_out so the divisor includes a partner core's sum.
module sfp_norm #(
  parameter int COL     = 8,
  parameter int PSUM_BW = 16,
  parameter int FRAC    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   acc,
  input  logic                   div,
  input  logic [COL*PSUM_BW-1:0] sfp_in,
  output logic [COL*PSUM_BW-1:0] sfp_out,
  output logic                   out_valid,
  output logic                   sfp_ready,
  output logic                   sum_valid,
  output logic [PSUM_BW+3:0]     sum_local
`ifdef SFP_EXT_SUM_EN
  ,
  input  logic [PSUM_BW+3:0]     sum_in,
  output logic [PSUM_BW+3:0]     sum_out
`endif
);

  localparam int SW = PSUM_BW + 4;
  localparam int DW = PSUM_BW + 5;
  localparam int CW = $clog2(FRAC + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DIV, S_DONE} state_t;

  state_t r_state, w_next;

  logic [COL*PSUM_BW-1:0] r_row;
  logic [COL*PSUM_BW-1:0] r_out;
  logic [SW-1:0]          r_sum;
  logic                   r_sum_valid;
  logic [DW-1:0]          r_d;
  logic [CW-1:0]          r_cnt;
  logic [DW:0]            r_rem  [COL];
  logic [FRAC:0]          r_quot [COL];
  logic [COL-1:0]         r_neg;

  logic                   w_acc_go;
  logic                   w_div_go;
  logic                   w_last;
  logic [DW-1:0]          w_d;
  logic [SW-1:0]          w_sum;
  logic [PSUM_BW-1:0]     w_abs       [COL];
  logic [DW:0]            w_rem_next  [COL];
  logic [FRAC:0]          w_quot_next [COL];
  logic [PSUM_BW-1:0]     w_mag       [COL];
  logic [PSUM_BW-1:0]     w_lane_out  [COL];

`ifdef SFP_EXT_SUM_EN
  assign w_d     = DW'(r_sum) + DW'(sum_in);
  assign sum_out = r_sum;
`else
  assign w_d     = DW'(r_sum);
`endif

  assign sfp_out   = r_out;
  assign sum_local = r_sum;
  assign sum_valid = r_sum_valid;
  assign sfp_ready = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign w_last    = (r_state == S_DIV) && (r_cnt == CW'(FRAC));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // acc has priority over div; commands only count in IDLE
  always_comb begin
    w_next   = r_state;
    w_acc_go = 1'b0;
    w_div_go = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (acc) begin
          w_acc_go = 1'b1;
          w_next   = S_ACCUM;
        end else if (div && r_sum_valid) begin
          w_div_go = 1'b1;
          w_next   = S_DIV;
        end
      end
      S_ACCUM: w_next = S_IDLE;
      S_DIV:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // the most negative lane maps to 2^(PSUM_BW-1) as an unsigned magnitude
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < COL; i++) begin
      if (r_row[i*PSUM_BW + PSUM_BW-1])
        w_abs[i] = ~r_row[i*PSUM_BW +: PSUM_BW] + PSUM_BW'(1);
      else
        w_abs[i] = r_row[i*PSUM_BW +: PSUM_BW];
      w_sum = w_sum + SW'(w_abs[i]);
    end
  end

  // fractional restoring step: remainder stays below 2*D, so one compare yields one bit
  always_comb begin
    for (int i = 0; i < COL; i++) begin
      if (r_rem[i] >= {1'b0, r_d}) begin
        w_rem_next[i]  = (r_rem[i] - {1'b0, r_d}) << 1;
        w_quot_next[i] = {r_quot[i][FRAC-1:0], 1'b1};
      end else begin
        w_rem_next[i]  = r_rem[i] << 1;
        w_quot_next[i] = {r_quot[i][FRAC-1:0], 1'b0};
      end
      w_mag[i] = PSUM_BW'(w_quot_next[i]);
      if (r_d == '0)
        w_lane_out[i] = '0;
      else if (r_neg[i])
        w_lane_out[i] = ~w_mag[i] + PSUM_BW'(1);
      else
        w_lane_out[i] = w_mag[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_row       <= '0;
      r_out       <= '0;
      r_sum       <= '0;
      r_sum_valid <= 1'b0;
      r_d         <= '0;
      r_cnt       <= '0;
      r_neg       <= '0;
      for (int i = 0; i < COL; i++) begin
        r_rem[i]  <= '0;
        r_quot[i] <= '0;
      end
    end else begin
      if (w_acc_go) r_row <= sfp_in;
      if (r_state == S_ACCUM) begin
        r_sum       <= w_sum;
        r_sum_valid <= 1'b1;
      end
      if (w_div_go) begin
        r_d   <= w_d;
        r_cnt <= '0;
        for (int i = 0; i < COL; i++) begin
          r_rem[i]  <= (DW+1)'(w_abs[i]);
          r_quot[i] <= '0;
          r_neg[i]  <= r_row[i*PSUM_BW + PSUM_BW-1];
        end
      end
      if (r_state == S_DIV) begin
        r_cnt <= r_cnt + CW'(1);
        for (int i = 0; i < COL; i++) begin
          r_rem[i]  <= w_rem_next[i];
          r_quot[i] <= w_quot_next[i];
          if (w_last) r_out[i*PSUM_BW +: PSUM_BW] <= w_lane_out[i];
        end
      end
      if (r_state == S_DONE) r_sum_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sfp_norm.sv
// Self-checking bench for sfp_norm: expected rows go into a scoreboard queue at div time
// and are compared whenever out_valid pulses.
module tb_sfp_norm;

   localparam int COL     = 8;
   localparam int PSUM_BW = 16;
   localparam int FRAC    = 8;
   localparam int SW      = PSUM_BW + 4;
   localparam int RW      = COL * PSUM_BW;

   logic          clk = 1'b0;
   logic          reset;
   logic          acc;
   logic          div;
   logic [RW-1:0] sfp_in;
   logic [RW-1:0] sfp_out;
   logic          out_valid;
   logic          sfp_ready;
   logic          sum_valid;
   logic [SW-1:0] sum_local;
`ifdef SFP_EXT_SUM_EN
   logic [SW-1:0] sum_in;
   logic [SW-1:0] sum_out;
`endif

   int            total = 0;
   int            bad   = 0;
   logic [RW-1:0] sbq[$];
   logic [RW-1:0] lastExp = '0;
   longint        tbSumIn = 0;

   sfp_norm #(.COL(COL), .PSUM_BW(PSUM_BW), .FRAC(FRAC)) dut (
      .clk       (clk),
      .reset     (reset),
      .acc       (acc),
      .div       (div),
      .sfp_in    (sfp_in),
      .sfp_out   (sfp_out),
      .out_valid (out_valid),
      .sfp_ready (sfp_ready),
      .sum_valid (sum_valid),
      .sum_local (sum_local)
`ifdef SFP_EXT_SUM_EN
      ,
      .sum_in    (sum_in),
      .sum_out   (sum_out)
`endif
   );

   // free-running clock, 10 time units per cycle
   always #5 clk = ~clk;

   // bound on total run time in case the design wedges
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog");
   end

   // scoreboard consumer: every out_valid pulse must match the oldest queued expectation
   always @(negedge clk) begin
      if (!reset && out_valid === 1'b1) begin
         total++;
         if (sbq.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected_out_valid: got sfp_out=%h with nothing expected", sfp_out);
         end else begin
            logic [RW-1:0] exp;
            exp = sbq.pop_front();
            if (sfp_out !== exp) begin
               bad++;
               $display("[TB] FAIL sfp_out: got %h expected %h", sfp_out, exp);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic longint laneVal(input logic [RW-1:0] row, input int i);
      logic signed [PSUM_BW-1:0] lv;
      lv = row[i*PSUM_BW +: PSUM_BW];
      return longint'(lv);
   endfunction

   function automatic longint modelSum(input logic [RW-1:0] row);
      longint s = 0;
      for (int i = 0; i < COL; i++) begin
         longint v = laneVal(row, i);
         s += (v < 0) ? -v : v;
      end
      return s;
   endfunction

   function automatic logic [RW-1:0] modelRow(input logic [RW-1:0] row, input longint sIn);
      logic [RW-1:0] res;
      longint d;
      d = modelSum(row) + sIn;
      res = '0;
      for (int i = 0; i < COL; i++) begin
         longint v = laneVal(row, i);
         longint a = (v < 0) ? -v : v;
         longint q = (d == 0) ? 0 : (a << FRAC) / d;
         res[i*PSUM_BW +: PSUM_BW] = PSUM_BW'((v < 0) ? -q : q);
      end
      return res;
   endfunction

   function automatic logic [RW-1:0] pack8(input int l [COL]);
      logic [RW-1:0] r;
      for (int i = 0; i < COL; i++) r[i*PSUM_BW +: PSUM_BW] = PSUM_BW'(l[i]);
      return r;
   endfunction

   task automatic doAcc(input logic [RW-1:0] row, input bit interfere, input string name);
      longint es = modelSum(row);
      sfp_in = row;
      acc    = 1'b1;
      tick();
      acc = 1'b0;
      if (interfere) div = 1'b1;
      tick();
      div = 1'b0;
      total++;
      if (sum_local !== SW'(es)) begin
         bad++;
         $display("[TB] FAIL %s_sum: got %0d expected %0d", name, sum_local, es);
      end
      total++;
      if (sum_valid !== 1'b1) begin
         bad++;
         $display("[TB] FAIL %s_sum_valid: got %b expected 1", name, sum_valid);
      end
   endtask

   task automatic doDiv(input logic [RW-1:0] row, input bit interfere, input string name);
      logic [RW-1:0] er = modelRow(row, tbSumIn);
      int lat;
      div = 1'b1;
      sbq.push_back(er);
      lastExp = er;
      tick();
      div = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 30) begin
         if (interfere && lat == 2) begin
            sfp_in = ~row;
            acc    = 1'b1;
            div    = 1'b1;
         end
         tick();
         acc = 1'b0;
         div = 1'b0;
         lat++;
      end
      total++;
      if (lat != FRAC + 2) begin
         bad++;
         $display("[TB] FAIL %s_latency: got %0d cycles expected %0d", name, lat, FRAC + 2);
      end
      tick();
      total++;
      if (out_valid !== 1'b0 || sum_valid !== 1'b0 || sfp_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL %s_after_done: got valid=%b sum_valid=%b ready=%b expected 0/0/1",
                  name, out_valid, sum_valid, sfp_ready);
      end
   endtask

   task automatic runRow(input logic [RW-1:0] row, input bit interfere, input string name);
      doAcc(row, interfere, name);
      doDiv(row, interfere, name);
      if (interfere) begin
         total++;
         if (sum_local !== SW'(modelSum(row))) begin
            bad++;
            $display("[TB] FAIL %s_sum_kept: got %0d expected %0d", name, sum_local, modelSum(row));
         end
      end
   endtask

   task automatic expectQuiet(input int cycles, input string name);
      int seen = 0;
      for (int c = 0; c < cycles; c++) begin
         tick();
         if (out_valid === 1'b1) seen++;
      end
      total++;
      if (seen != 0) begin
         bad++;
         $display("[TB] FAIL %s_no_out_valid: got %0d pulses expected 0", name, seen);
      end
   endtask

   task automatic test_reset();
      reset  = 1'b1;
      acc    = 1'b0;
      div    = 1'b0;
      sfp_in = '0;
      tick();
      tick();
      reset = 1'b0;
      total++;
      if (sfp_ready !== 1'b1 || out_valid !== 1'b0 || sum_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL reset_flags: got ready=%b valid=%b sum_valid=%b expected 1/0/0",
                  sfp_ready, out_valid, sum_valid);
      end
      total++;
      if (sum_local !== '0 || sfp_out !== '0) begin
         bad++;
         $display("[TB] FAIL reset_data: got sum=%0d out=%h expected 0/0", sum_local, sfp_out);
      end
   endtask

   task automatic test_directed();
      int l [COL];
      l = '{100, -100, 0, 0, 0, 0, 0, 0};
      runRow(pack8(l), 1'b0, "pair");
      l = '{1, 1, 1, 1, 1, 1, 1, 1};
      runRow(pack8(l), 1'b0, "ones");
      l = '{-32768, 0, 0, 0, 0, 0, 0, 0};
      runRow(pack8(l), 1'b0, "minneg");
      l = '{0, 0, 0, 0, 0, 0, 0, 0};
      runRow(pack8(l), 1'b0, "zero");
      l = '{32767, -32768, 32767, -32768, 32767, -32768, 32767, -32768};
      runRow(pack8(l), 1'b0, "extreme");
   endtask

   task automatic test_ignore();
      int l [COL];
      logic [RW-1:0] row;
      div = 1'b1;
      tick();
      div = 1'b0;
      total++;
      if (sfp_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL div_no_sum_ready: got %b expected 1", sfp_ready);
      end
      expectQuiet(FRAC + 4, "div_no_sum");
      l = '{3, -5, 7, 0, 0, 0, 0, 9};
      row = pack8(l);
      sfp_in = row;
      acc    = 1'b1;
      div    = 1'b1;
      tick();
      acc = 1'b0;
      div = 1'b0;
      total++;
      if (sfp_ready !== 1'b0) begin
         bad++;
         $display("[TB] FAIL acc_div_same_cycle_ready: got %b expected 0", sfp_ready);
      end
      tick();
      total++;
      if (sum_valid !== 1'b1 || sum_local !== SW'(modelSum(row))) begin
         bad++;
         $display("[TB] FAIL acc_div_same_cycle_sum: got valid=%b sum=%0d expected 1/%0d",
                  sum_valid, sum_local, modelSum(row));
      end
      expectQuiet(FRAC + 4, "acc_div_same_cycle");
      doDiv(row, 1'b0, "after_acc_div");
   endtask

   task automatic test_overwrite_hold();
      int l [COL];
      logic [RW-1:0] rowA;
      logic [RW-1:0] rowB;
      l = '{50, 50, 0, 0, 0, 0, 0, 0};
      rowA = pack8(l);
      l = '{-20, 10, 10, 0, 0, 0, 0, 40};
      rowB = pack8(l);
      runRow(rowA, 1'b0, "hold_prep");
      doAcc(rowB, 1'b0, "overwrite_a");
      total++;
      if (sfp_out !== lastExp) begin
         bad++;
         $display("[TB] FAIL hold_out: got %h expected %h", sfp_out, lastExp);
      end
      doAcc(rowA, 1'b0, "overwrite_b");
      doAcc(rowB, 1'b0, "overwrite_c");
      doDiv(rowB, 1'b0, "overwrite");
   endtask

   task automatic test_reset_abort();
      int l [COL];
      logic [RW-1:0] row;
      l = '{10, 20, -30, 40, 0, 0, 0, 0};
      row = pack8(l);
      doAcc(row, 1'b0, "abort");
      div = 1'b1;
      sbq.push_back(modelRow(row, tbSumIn));
      tick();
      div = 1'b0;
      tick();
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      sbq.delete();
      lastExp = '0;
      total++;
      if (sfp_ready !== 1'b1 || sum_valid !== 1'b0 || out_valid !== 1'b0) begin
         bad++;
         $display("[TB] FAIL abort_flags: got ready=%b sum_valid=%b valid=%b expected 1/0/0",
                  sfp_ready, sum_valid, out_valid);
      end
      expectQuiet(FRAC + 4, "abort");
      div = 1'b1;
      tick();
      div = 1'b0;
      expectQuiet(FRAC + 4, "abort_div_after");
   endtask

   task automatic test_back_to_back();
      logic [RW-1:0] row;
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < COL; i++) row[i*PSUM_BW +: PSUM_BW] = PSUM_BW'($urandom);
         if (k == 3) row[2*PSUM_BW +: PSUM_BW] = '0;
         runRow(row, bit'(k % 2), $sformatf("rand%0d", k));
      end
   endtask

`ifdef SFP_EXT_SUM_EN
   task automatic test_ext_sum();
      int l [COL];
      logic [RW-1:0] row;
      l = '{100, 0, 0, 0, 0, 0, 0, 0};
      row = pack8(l);
      tbSumIn = 300;
      sum_in  = SW'(300);
      doAcc(row, 1'b0, "ext");
      total++;
      if (sum_out !== SW'(100)) begin
         bad++;
         $display("[TB] FAIL ext_sum_out: got %0d expected 100", sum_out);
      end
      doDiv(row, 1'b0, "ext");
      total++;
      if (sfp_out[PSUM_BW-1:0] !== PSUM_BW'(64)) begin
         bad++;
         $display("[TB] FAIL ext_lane0: got %0d expected 64", sfp_out[PSUM_BW-1:0]);
      end
      tbSumIn = 0;
      sum_in  = '0;
   endtask
`endif

   initial begin
`ifdef SFP_EXT_SUM_EN
      sum_in = '0;
`endif
      $display("[TB] starting sfp_norm bench");
      test_reset();
      test_directed();
      test_ignore();
      test_overwrite_hold();
      test_reset_abort();
      test_back_to_back();
`ifdef SFP_EXT_SUM_EN
      test_ext_sum();
`endif
      tick();
      total++;
      if (sbq.size() != 0) begin
         bad++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
